asym_ram_fifo_ctrl: RTL and testbench
=====================================

Name: asym_ram_fifo_ctrl

Overview:
- Single-clock FIFO controller that sequences an asymmetric dual-port RAM: bytes in on port A (256x8 write), 32-bit words out on port B (64x32 read).
- Owns write/read pointers, occupancy, full/empty and the ready/valid handshakes on both sides.
- Drives RAM enables, write-enables and addresses; the RAM array itself stays external.
- Used as the byte-stream-to-word converter in front of 32-bit consumers.

Parameters:
- WIDTHA, 8, port A (write side) data width.
- ADDRWIDTHA, 8, port A address width; depth SIZEA = 2**ADDRWIDTHA bytes.
- WIDTHB, 32, port B (read side) data width; must be WIDTHA*2**k.
- ADDRWIDTHB, 6, port B address width; equals ADDRWIDTHA - log2(WIDTHB/WIDTHA).
- Localparams: RATIO = WIDTHB/WIDTHA (4); LOG2RATIO (2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of pointers and read state.
- wr_valid  in  1  byte present on wr_data.
- wr_data  in  WIDTHA  write byte.
- wr_ready  out  1  controller accepts a byte this cycle.
- rd_valid  out  1  rd_data holds an unconsumed word.
- rd_data  out  WIDTHB  read word; wired from ram_doB.
- rd_ready  in  1  consumer takes the word.
- level  out  ADDRWIDTHA+1  bytes stored, 0..SIZEA.
- ram_enA, ram_weA  out  1  RAM port A enable and write-enable.
- ram_addrA  out  ADDRWIDTHA  RAM port A byte address.
- ram_diA  out  WIDTHA  RAM port A write data.
- ram_enB  out  1  RAM port B enable; this controller never drives weB.
- ram_addrB  out  ADDRWIDTHB  RAM port B word address.
- ram_doB  in  WIDTHB  RAM port B registered read data. ram_doB updates only on a cycle with ram_enB high, with 1-cycle latency.

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, FSM=IDLE, rd_valid=0, level=0, wr_ready=1.
  - All RAM controls are 0 while in reset.
- Pointers:
  - wr_ptr: ADDRWIDTHA+1 bits, counts bytes.
  - rd_ptr: ADDRWIDTHB+1 bits, counts words.
  - Both wrap modulo 2**width, so the MSB acts as the lap bit.
- level = wr_ptr - {rd_ptr, LOG2RATIO'b0}, modulo 2**(ADDRWIDTHA+1).
- words_avail = (wr_ptr >> LOG2RATIO) - rd_ptr. A partial word (fewer than RATIO bytes) is never readable.
- Write side:
  - wr_ready = (level != SIZEA) & ~flush.
  - On wr_valid & wr_ready: ram_enA = ram_weA = 1, ram_addrA = wr_ptr[ADDRWIDTHA-1:0], ram_diA = wr_data, wr_ptr += 1.
  - ram_enA is 0 on all other cycles.
- Byte order: the first byte of a word lands in rd_data[WIDTHA-1:0] (little-endian packing).
- Read FSM, IDLE state:
  - rd_valid=0.
  - If words_avail != 0: assert ram_enB, set ram_addrB = rd_ptr[ADDRWIDTHB-1:0], rd_ptr += 1, go to VALID.
- Read FSM, VALID state:
  - rd_valid=1; rd_data = ram_doB, held stable until accepted.
  - On rd_ready with words_avail != 0: issue the next read the same cycle (ram_enB high, rd_ptr += 1) and stay in VALID. This gives 1 word per cycle.
  - On rd_ready with words_avail == 0: go to IDLE.
  - Without rd_ready: no ram_enB.
- Space is freed at read issue; the slot may be rewritten the next cycle because ram_doB already holds the word.
- Write/read in the same cycle: both take effect. level changes by +1 for the write and -RATIO for the read issue.
  - Addresses never collide: reads only touch complete words behind wr_ptr.
- Full: level == SIZEA; wr_ready=0. A word read issued that cycle makes wr_ready 1 the next cycle.
- Empty: words_avail == 0 with FSM in IDLE; rd_valid=0 even if 1..RATIO-1 bytes are pending.
- flush, next edge: pointers 0, FSM IDLE, rd_valid 0. No RAM enables while flush is high; it overrides any concurrent write or read.
- Reset mid-transfer: immediate return to the reset state. RAM contents are not cleared.
- Latency: 4th byte accepted at edge t → ram_enB high in cycle t+1 → rd_valid at t+2.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles with rd_ready=1 → rd_valid 2 cycles after the 4th byte, rd_data=0x44332211, level returns to 0.
- Write 3 bytes only → rd_valid stays 0, level=3. Then a 4th byte 0xAA → word {0xAA, b2, b1, b0} is delivered.
- Write 256 bytes with rd_ready=0 → 1 word is fetched, so level=252 and writing continues to level=256. wr_ready drops and a 257th wr_valid is ignored (wr_ptr unchanged).
- Preload 8 words, hold rd_ready=1 → 8 consecutive rd_valid cycles, ram_addrB 0..7, data in order.
- Stream 1000 bytes (pointer wrap) with random wr_valid/rd_ready → all 250 words match the reference model; level never exceeds 256.
- Assert flush, and separately rst_n low, while in VALID with level=100 → rd_valid=0 and level=0 next cycle; a new 4-byte sequence is read from word 0.

Source files
------------

// File: rtl/asym_ram_fifo_ctrl_if.sv
// Byte-in / word-out handshake bundle for asym_ram_fifo_ctrl.
// Master is the producer/consumer side; slave is the controller.
interface asym_ram_fifo_ctrl_if #(
  parameter int WIDTHA = 8,
  parameter int WIDTHB = 32
);
  logic              wr_valid;
  logic [WIDTHA-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [WIDTHB-1:0] rd_data;
  logic              rd_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output rd_valid,
    output rd_data,
    input  rd_ready
  );
endinterface

// File: rtl/asym_ram_fifo_ctrl.sv
// FIFO controller for an asymmetric RAM: bytes written on port A,
// little-endian packed words read on port B with a 1-cycle RAM latency.
module asym_ram_fifo_ctrl #(
  parameter int WIDTHA     = 8,
  parameter int ADDRWIDTHA = 8,
  parameter int WIDTHB     = 32,
  parameter int ADDRWIDTHB = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  asym_ram_fifo_ctrl_if.slave   bus,
  output logic [ADDRWIDTHA:0]   level,
  output logic                  ram_enA,
  output logic                  ram_weA,
  output logic [ADDRWIDTHA-1:0] ram_addrA,
  output logic [WIDTHA-1:0]     ram_diA,
  output logic                  ram_enB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [WIDTHB-1:0]     ram_doB
);

  localparam int RATIO     = WIDTHB / WIDTHA;
  localparam int LOG2RATIO = $clog2(RATIO);

  localparam logic [ADDRWIDTHA:0] SIZEA =
    {1'b1, {ADDRWIDTHA{1'b0}}};
  localparam logic [ADDRWIDTHA:0] WR_ONE =
    (ADDRWIDTHA+1)'(1);
  localparam logic [ADDRWIDTHB:0] RD_ONE =
    (ADDRWIDTHB+1)'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  logic [ADDRWIDTHA:0] r_wr_ptr;
  logic [ADDRWIDTHB:0] r_rd_ptr;
  logic [0:0]          r_state;

  logic [0:0]          w_state_nxt;
  logic [ADDRWIDTHA:0] w_level;
  logic [ADDRWIDTHB:0] w_wr_words;
  logic [ADDRWIDTHB:0] w_words_avail;
  logic                w_avail;
  logic                w_wr_ready;
  logic                w_wr_fire;
  logic                w_rd_issue;

  // Occupancy in bytes; read space is freed as soon as a word read issues.
  assign w_level = r_wr_ptr - {r_rd_ptr, {LOG2RATIO{1'b0}}};
  assign level   = w_level;

  // Only complete words count; a trailing partial word stays invisible.
  assign w_wr_words    = r_wr_ptr[ADDRWIDTHA:LOG2RATIO];
  assign w_words_avail = w_wr_words - r_rd_ptr;
  assign w_avail       = (w_words_avail != '0);

  assign w_wr_ready   = (w_level != SIZEA) & ~flush;
  assign bus.wr_ready = w_wr_ready;

  // rst_n gating keeps the RAM strobes quiet while reset is held.
  assign w_wr_fire = rst_n & bus.wr_valid & w_wr_ready;

  // Issue from IDLE, or back-to-back in VALID when the word is taken.
  assign w_rd_issue = rst_n & ~flush & w_avail &
                      ((r_state == ST_IDLE) | bus.rd_ready);

  assign ram_enA   = w_wr_fire;
  assign ram_weA   = w_wr_fire;
  assign ram_addrA = r_wr_ptr[ADDRWIDTHA-1:0];
  assign ram_diA   = w_wr_fire ? bus.wr_data : '0;

  assign ram_enB   = w_rd_issue;
  assign ram_addrB = r_rd_ptr[ADDRWIDTHB-1:0];

  // ram_doB only moves on an issue, so it holds until the word is taken.
  assign bus.rd_valid = (r_state == ST_VALID);
  assign bus.rd_data  = ram_doB;

  // Read FSM next-state: flush wins, otherwise IDLE/VALID handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_avail) w_state_nxt = ST_VALID;
        end
        ST_VALID: begin
          if (bus.rd_ready && !w_avail)
            w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Byte write pointer, MSB is the lap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + WR_ONE;
    end
  end

  // Word read pointer, advanced at read issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
    end else if (w_rd_issue) begin
      r_rd_ptr <= r_rd_ptr + RD_ONE;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

endmodule

// File: tb/tb_asym_ram_fifo_ctrl.sv
// Directed bench for asym_ram_fifo_ctrl with a behavioural asymmetric RAM.
// Expected words are built from the bytes the bench itself sends.
module tb_asym_ram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [8:0]  level;
  logic        ram_enA;
  logic        ram_weA;
  logic [7:0]  ram_addrA;
  logic [7:0]  ram_diA;
  logic        ram_enB;
  logic [5:0]  ram_addrB;
  logic [31:0] ram_doB;

  int total;
  int bad;

  asym_ram_fifo_ctrl_if #(.WIDTHA(8), .WIDTHB(32)) bus ();

  asym_ram_fifo_ctrl #(
    .WIDTHA(8), .ADDRWIDTHA(8),
    .WIDTHB(32), .ADDRWIDTHB(6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .level     (level),
    .ram_enA   (ram_enA),
    .ram_weA   (ram_weA),
    .ram_addrA (ram_addrA),
    .ram_diA   (ram_diA),
    .ram_enB   (ram_enB),
    .ram_addrB (ram_addrB),
    .ram_doB   (ram_doB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (ram_enA && ram_weA) mem[ram_addrA] <= ram_diA;
    if (ram_enB)
      ram_doB <= {mem[{ram_addrB, 2'd3}], mem[{ram_addrB, 2'd2}],
                  mem[{ram_addrB, 2'd1}], mem[{ram_addrB, 2'd0}]};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  function automatic logic [31:0] wseq(input int base, input int j);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(base + 4*j + k);
    return w;
  endfunction

  logic [7:0]  q[$];
  logic [31:0] ew;
  int sent, got, cyc, maxlvl;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    bus.rd_ready = 1'b0;
    #3;
    chk("rst_level",    32'(level), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_enA",      32'(ram_enA), 32'd0);
    chk("rst_weA",      32'(ram_weA), 32'd0);
    chk("rst_enB",      32'(ram_enB), 32'd0);
    bus.wr_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // four bytes -> one word, 2-cycle latency
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h11 * (i + 1));
      settle();
      chk("w1_enA",   32'(ram_enA), 32'd1);
      chk("w1_addrA", 32'(ram_addrA), 32'(i));
      chk("w1_diA",   32'(ram_diA), 32'(8'h11 * (i + 1)));
      tick();
    end
    bus.wr_valid = 1'b0;
    settle();
    chk("w1_enB",     32'(ram_enB), 32'd1);
    chk("w1_addrB",   32'(ram_addrB), 32'd0);
    chk("w1_novalid", 32'(bus.rd_valid), 32'd0);
    chk("w1_level4",  32'(level), 32'd4);
    tick();
    chk("w1_valid",   32'(bus.rd_valid), 32'd1);
    chk("w1_data",    bus.rd_data, 32'h44332211);
    chk("w1_level0",  32'(level), 32'd0);
    chk("w1_enB_off", 32'(ram_enB), 32'd0);
    tick();
    chk("w1_idle",    32'(bus.rd_valid), 32'd0);

    // partial word is not readable
    wr_byte(8'h01);
    wr_byte(8'h02);
    wr_byte(8'h03);
    tick();
    tick();
    chk("p3_valid", 32'(bus.rd_valid), 32'd0);
    chk("p3_level", 32'(level), 32'd3);
    chk("p3_enB",   32'(ram_enB), 32'd0);
    wr_byte(8'hAA);
    settle();
    chk("p4_enB",   32'(ram_enB), 32'd1);
    tick();
    chk("p4_valid", 32'(bus.rd_valid), 32'd1);
    chk("p4_data",  bus.rd_data, 32'hAA030201);
    tick();
    chk("p4_idle",  32'(bus.rd_valid), 32'd0);
    chk("p4_level", 32'(level), 32'd0);

    // fill to full with consumer stalled
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 256; i++) wr_byte(8'(i));
    settle();
    chk("f_level252", 32'(level), 32'd252);
    chk("f_ready252", 32'(bus.wr_ready), 32'd1);
    chk("f_valid",    32'(bus.rd_valid), 32'd1);
    for (int i = 256; i < 260; i++) wr_byte(8'(i));
    settle();
    chk("f_level256", 32'(level), 32'd256);
    chk("f_full",     32'(bus.wr_ready), 32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hFF;
    settle();
    chk("f_enA_full", 32'(ram_enA), 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    settle();
    chk("f_level_hold", 32'(level), 32'd256);
    chk("f_word0",      bus.rd_data, 32'h03020100);
    bus.rd_ready = 1'b1;
    settle();
    chk("f_enB",       32'(ram_enB), 32'd1);
    chk("f_ready_now", 32'(bus.wr_ready), 32'd0);
    tick();
    chk("f_ready_next", 32'(bus.wr_ready), 32'd1);
    chk("f_level_drop", 32'(level), 32'd252);
    chk("f_word1",      bus.rd_data, wseq(0, 1));
    for (int j = 2; j <= 64; j++) begin
      tick();
      chk("f_drain_v", 32'(bus.rd_valid), 32'd1);
      chk("f_drain_d", bus.rd_data, wseq(0, j));
    end
    tick();
    chk("f_empty_v", 32'(bus.rd_valid), 32'd0);
    chk("f_empty_l", 32'(level), 32'd0);

    // flush, preload 8 words, stream them back to back
    flush = 1'b1;
    settle();
    chk("fl_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    flush = 1'b0;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h40 + i);
      settle();
      if (i == 4) begin
        chk("b8_enB0",  32'(ram_enB), 32'd1);
        chk("b8_addr0", 32'(ram_addrB), 32'd0);
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("b8_valid", 32'(bus.rd_valid), 32'd1);
      chk("b8_data",  bus.rd_data, wseq(8'h40, k));
      if (k < 7) begin
        chk("b8_enB",  32'(ram_enB), 32'd1);
        chk("b8_addr", 32'(ram_addrB), 32'(k + 1));
      end
      tick();
    end
    chk("b8_idle", 32'(bus.rd_valid), 32'd0);

    // random stream across pointer wrap against a byte queue
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sent = 0;
    got = 0;
    cyc = 0;
    maxlvl = 0;
    while ((sent < 1000 || got < 250) && cyc < 20000) begin
      bus.wr_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.wr_data  = 8'($urandom);
      bus.rd_ready = ($urandom_range(0, 2) != 0);
      settle();
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (bus.wr_valid && bus.wr_ready) begin
        q.push_back(bus.wr_data);
        sent++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (q.size() >= 4) begin
          ew = {q[3], q[2], q[1], q[0]};
          repeat (4) void'(q.pop_front());
        end else begin
          ew = 32'hDEAD_BEEF;
        end
        chk("rs_word", bus.rd_data, ew);
        got++;
      end
      tick();
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    chk("rs_words", 32'(got), 32'd250);
    chk("rs_maxlvl_ok", 32'(maxlvl <= 256), 32'd1);
    tick();
    chk("rs_level0", 32'(level), 32'd0);

    // flush while VALID at level 100
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 104; i++) wr_byte(8'(i));
    settle();
    chk("fv_level", 32'(level), 32'd100);
    chk("fv_valid", 32'(bus.rd_valid), 32'd1);
    flush = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    settle();
    chk("fv_enA", 32'(ram_enA), 32'd0);
    chk("fv_enB", 32'(ram_enB), 32'd0);
    chk("fv_rdy", 32'(bus.wr_ready), 32'd0);
    tick();
    flush = 1'b0;
    bus.wr_valid = 1'b0;
    settle();
    chk("fv_cleared_v", 32'(bus.rd_valid), 32'd0);
    chk("fv_cleared_l", 32'(level), 32'd0);
    wr_byte(8'hDE);
    wr_byte(8'hAD);
    wr_byte(8'hBE);
    wr_byte(8'hEF);
    settle();
    chk("fv_enB_new",  32'(ram_enB), 32'd1);
    chk("fv_addr_new", 32'(ram_addrB), 32'd0);
    tick();
    chk("fv_data_new", bus.rd_data, 32'hEFBEADDE);
    tick();

    // async reset while VALID at level 100
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 104; i++) wr_byte(8'(i + 7));
    settle();
    chk("rv_level", 32'(level), 32'd100);
    chk("rv_valid", 32'(bus.rd_valid), 32'd1);
    rst_n = 1'b0;
    settle();
    chk("rv_async_v", 32'(bus.rd_valid), 32'd0);
    chk("rv_async_l", 32'(level), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rd_ready = 1'b1;
    wr_byte(8'h12);
    wr_byte(8'h34);
    wr_byte(8'h56);
    wr_byte(8'h78);
    settle();
    chk("rv_enB_new",  32'(ram_enB), 32'd1);
    chk("rv_addr_new", 32'(ram_addrB), 32'd0);
    tick();
    chk("rv_valid_new", 32'(bus.rd_valid), 32'd1);
    chk("rv_data_new",  bus.rd_data, 32'h78563412);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
